// File: rtl/osc_adc_pkg.sv
// Shared definitions for the serial ADC responder.
// Holds the frame length, control-word bit positions, the DOUT header
// layout and the responder state type.
package osc_adc_pkg;

    localparam int unsigned FRAME_BITS = 16;

    // Control word fields (MSB first on ADC_DIN)
    localparam int unsigned CTRL_WRITE   = 15;
    localparam int unsigned CTRL_ADD_MSB = 12;
    localparam int unsigned CTRL_ADD_LSB = 10;
    localparam int unsigned CHAN_W       = CTRL_ADD_MSB - CTRL_ADD_LSB + 1;

    // DOUT frame = {1'b0, channel[2:0], sample[DATA_W-1:0]}
    localparam int unsigned HDR_W = 1 + CHAN_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } adc_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with rise/fall pulse detection.
// Ports:
//   CLK, RSTB - system clock, async active-low reset
//   d_i       - asynchronous input
//   sync_o    - synchronized level (last synchronizer stage)
//   rise_o    - one-cycle pulse on synchronized rising edge
//   fall_o    - one-cycle pulse on synchronized falling edge
// Edges appear SYNC_STAGES+1 clocks after the pin changes.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RSTB,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset low: a CS_N held low across reset must not look like a new frame start.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave emulating an 8-channel, 12-bit serial ADC for loopback bring-up.
// Ports:
//   CLK, RSTB                    - 50 MHz system clock, async active-low reset
//   ADC_CS_N, ADC_SCLK, ADC_DIN  - master frame select, serial clock, control data
//   ADC_DOUT                     - {0, channel, sample}, MSB first, updated on SCLK fall
//   sample_in/valid, sample_ready- sample stream; ready pulses once per frame start
//   ctrl_word, ctrl_valid        - last complete control word and its update pulse
//   channel                      - channel address, applied from the next frame
//   frame_err                    - pulse when CS_N rises before a frame completes
//   underrun_cnt                 - saturating count of frames started without a sample
// Build option: define ADC_TEST_PATTERN_EN to replace the sample stream with an
// internal ramp advancing by RAMP_STEP per frame.
module adc_spi_responder #(
    parameter int unsigned       DATA_W      = 12,
    parameter int unsigned       FRAME_BITS  = osc_adc_pkg::FRAME_BITS,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RAMP_STEP   = DATA_W'(16)
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              ADC_CS_N,
    input  logic              ADC_SCLK,
    input  logic              ADC_DIN,
    output logic              ADC_DOUT,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic [15:0]       ctrl_word,
    output logic              ctrl_valid,
    output logic [2:0]        channel,
    output logic              frame_err,
    output logic [7:0]        underrun_cnt
);

    import osc_adc_pkg::*;

    localparam int unsigned TX_W  = FRAME_BITS;
    localparam int unsigned PAD   = FRAME_BITS - HDR_W - DATA_W;
    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    logic cs_sync, cs_rise, cs_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic din_sync, unused_din_rise, unused_din_fall, unused_sclk_sync, unused_cs_rise;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .CLK    (CLK),
        .RSTB   (RSTB),
        .d_i    (ADC_CS_N),
        .sync_o (cs_sync),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .CLK    (CLK),
        .RSTB   (RSTB),
        .d_i    (ADC_SCLK),
        .sync_o (sclk_sync),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
        .CLK    (CLK),
        .RSTB   (RSTB),
        .d_i    (ADC_DIN),
        .sync_o (din_sync),
        .rise_o (unused_din_rise),
        .fall_o (unused_din_fall)
    );

    // Abort is detected on CS_N level so a rise during LOAD is not lost.
    assign unused_sclk_sync = sclk_sync;
    assign unused_cs_rise   = cs_rise;

    adc_state_e          state_q, state_d;
    logic [TX_W-1:0]     tx_q, tx_d;
    logic [15:0]         rx_q, rx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   held_q, held_d;
    logic                dout_q, dout_d;
    logic                ready_q, ready_d;
    logic [15:0]         ctrl_q, ctrl_d;
    logic                cvalid_q, cvalid_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic                ferr_q, ferr_d;
    logic [7:0]          und_q, und_d;
    logic [DATA_W-1:0]   ramp_q, ramp_d;

`ifdef ADC_TEST_PATTERN_EN
    logic [DATA_W:0] unused_stream;
    assign unused_stream = {sample_in, sample_valid};
`else
    logic [DATA_W-1:0] unused_ramp_step;
    assign unused_ramp_step = RAMP_STEP;
`endif

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cnt_d    = cnt_q;
        held_d   = held_q;
        dout_d   = 1'b0;
        ready_d  = 1'b0;
        ctrl_d   = ctrl_q;
        cvalid_d = 1'b0;
        chan_d   = chan_q;
        ferr_d   = 1'b0;
        und_d    = und_q;
        ramp_d   = ramp_q;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = LOAD;
`ifndef ADC_TEST_PATTERN_EN
                    // Registered so the pulse lines up with the LOAD cycle.
                    ready_d = 1'b1;
`endif
                end
            end
            LOAD: begin
`ifdef ADC_TEST_PATTERN_EN
                tx_d   = TX_W'({1'b0, chan_q, ramp_q}) << PAD;
                ramp_d = ramp_q + RAMP_STEP;
`else
                if (sample_valid) begin
                    tx_d   = TX_W'({1'b0, chan_q, sample_in}) << PAD;
                    held_d = sample_in;
                end else begin
                    tx_d = TX_W'({1'b0, chan_q, held_q}) << PAD;
                    if (und_q != 8'hFF) begin
                        und_d = und_q + 8'd1;
                    end
                end
`endif
                cnt_d   = '0;
                dout_d  = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                dout_d = dout_q;
                if (sclk_fall) begin
                    tx_d   = tx_q << 1;
                    dout_d = tx_q[TX_W-2];
                end
                if (sclk_rise) begin
                    rx_d  = {rx_q[14:0], din_sync};
                    cnt_d = cnt_q + 1'b1;
                end
                // Completion wins over a simultaneous CS_N rise.
                if (sclk_rise && (cnt_q == CNT_W'(FRAME_BITS - 1))) begin
                    ctrl_d   = rx_d;
                    cvalid_d = 1'b1;
                    if (rx_d[CTRL_WRITE]) begin
                        chan_d = rx_d[CTRL_ADD_MSB:CTRL_ADD_LSB];
                    end
                    dout_d  = 1'b0;
                    state_d = DONE;
                end else if (cs_sync) begin
                    ferr_d  = 1'b1;
                    dout_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (cs_sync) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= IDLE;
            tx_q     <= '0;
            rx_q     <= '0;
            cnt_q    <= '0;
            held_q   <= '0;
            dout_q   <= 1'b0;
            ready_q  <= 1'b0;
            ctrl_q   <= '0;
            cvalid_q <= 1'b0;
            chan_q   <= '0;
            ferr_q   <= 1'b0;
            und_q    <= '0;
            ramp_q   <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            dout_q   <= dout_d;
            ready_q  <= ready_d;
            ctrl_q   <= ctrl_d;
            cvalid_q <= cvalid_d;
            chan_q   <= chan_d;
            ferr_q   <= ferr_d;
            und_q    <= und_d;
            ramp_q   <= ramp_d;
        end
    end

    assign ADC_DOUT     = dout_q;
    assign sample_ready = ready_q;
    assign ctrl_word    = ctrl_q;
    assign ctrl_valid   = cvalid_q;
    assign channel      = chan_q;
    assign frame_err    = ferr_q;
    assign underrun_cnt = und_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
`timescale 1ns/1ps
module tb_adc_spi_responder;

    logic        CLK = 1'b0;
    logic        RSTB = 1'b0;
    logic        ADC_CS_N = 1'b1;
    logic        ADC_SCLK = 1'b0;
    logic        ADC_DIN = 1'b0;
    logic        ADC_DOUT;
    logic [11:0] sample_in = 12'h000;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] ctrl_word;
    logic        ctrl_valid;
    logic [2:0]  channel;
    logic        frame_err;
    logic [7:0]  underrun_cnt;

    adc_spi_responder dut (
        .CLK          (CLK),
        .RSTB         (RSTB),
        .ADC_CS_N     (ADC_CS_N),
        .ADC_SCLK     (ADC_SCLK),
        .ADC_DIN      (ADC_DIN),
        .ADC_DOUT     (ADC_DOUT),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .ctrl_word    (ctrl_word),
        .ctrl_valid   (ctrl_valid),
        .channel      (channel),
        .frame_err    (frame_err),
        .underrun_cnt (underrun_cnt)
    );

    always #10 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_pulses = 0;
    logic [11:0] tb_ramp = 12'h000;

    // Scoreboard queues: expectations pushed by stimulus, observations by the master.
    logic [15:0] exp_ctrl_q[$];
    logic [2:0]  exp_chan_q[$];
    logic [15:0] exp_err_q[$];
    logic [31:0] exp_dout_q[$];
    logic [31:0] got_dout_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compares whenever the DUT presents a result.
    always @(negedge CLK) begin
        if (sample_ready) ready_pulses++;
        if (ctrl_valid) begin
            if (exp_ctrl_q.size() == 0) begin
                check("unexpected ctrl_valid", 32'(ctrl_valid), 32'd0);
            end else begin
                check("ctrl_word", 32'(ctrl_word), 32'(exp_ctrl_q.pop_front()));
                check("channel", 32'(channel), 32'(exp_chan_q.pop_front()));
            end
        end
        if (frame_err) begin
            if (exp_err_q.size() == 0) begin
                check("unexpected frame_err", 32'(frame_err), 32'd0);
            end else begin
                check("ctrl_word kept on abort", 32'(ctrl_word), 32'(exp_err_q.pop_front()));
            end
        end
        if (got_dout_q.size() > 0) begin
            if (exp_dout_q.size() == 0) begin
                check("unexpected dout frame", got_dout_q.pop_front(), 32'd0);
            end else begin
                check("dout frame", got_dout_q.pop_front(), exp_dout_q.pop_front());
            end
        end
    end

    // SPI master, SCLK = CLK/8, DIN changes on SCLK fall, DOUT sampled on SCLK rise.
    task automatic run_frame(input logic [15:0] ctrl, input int nclk, input int abort_at,
                             output logic [31:0] rd);
        rd = 32'd0;
        @(negedge CLK);
        ADC_CS_N = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < nclk; i++) begin
            ADC_DIN = (i < 16) ? ctrl[15 - i] : 1'b0;
            repeat (4) @(negedge CLK);
            ADC_SCLK = 1'b1;
            rd = {rd[30:0], ADC_DOUT};
            repeat (4) @(negedge CLK);
            ADC_SCLK = 1'b0;
            if (abort_at == i + 1) break;
        end
        repeat (4) @(negedge CLK);
        ADC_CS_N = 1'b1;
        ADC_DIN  = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    task automatic full_frame(input logic [11:0] smp, input logic vld, input logic [15:0] ctrl,
                              input int nclk, input logic [2:0] hdr_ch, input logic [11:0] data,
                              input logic [2:0] ch_after);
        logic [31:0] rd;
        logic [31:0] e;
        logic [11:0] d;
        d = data;
`ifdef ADC_TEST_PATTERN_EN
        d = tb_ramp;
        tb_ramp = tb_ramp + 12'd16;
`endif
        sample_in    = smp;
        sample_valid = vld;
        e = {16'h0000, 1'b0, hdr_ch, d};
        e = e << (nclk - 16);
        exp_ctrl_q.push_back(ctrl);
        exp_chan_q.push_back(ch_after);
        exp_dout_q.push_back(e);
        run_frame(ctrl, nclk, 0, rd);
        got_dout_q.push_back(rd);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " ADC_DOUT"}, 32'(ADC_DOUT), 32'd0);
        check({tag, " sample_ready"}, 32'(sample_ready), 32'd0);
        check({tag, " ctrl_word"}, 32'(ctrl_word), 32'd0);
        check({tag, " ctrl_valid"}, 32'(ctrl_valid), 32'd0);
        check({tag, " channel"}, 32'(channel), 32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " underrun_cnt"}, 32'(underrun_cnt), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int exp_und;
        int exp_ready;
`ifdef ADC_TEST_PATTERN_EN
        exp_und   = 0;
        exp_ready = 0;
`else
        exp_und   = 1;
        exp_ready = 9;
`endif
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RSTB = 1'b1;
        repeat (4) @(negedge CLK);

        // Basic frame, then a channel write, then the new channel in the header.
        full_frame(12'hA5C, 1'b1, 16'h0000, 16, 3'd0, 12'hA5C, 3'd0);
        full_frame(12'h456, 1'b1, 16'h8C00, 16, 3'd0, 12'h456, 3'd3);
        full_frame(12'h123, 1'b1, 16'h0000, 16, 3'd3, 12'h123, 3'd3);
        // Underrun: previous sample is resent.
        full_frame(12'hFFF, 1'b0, 16'h0000, 16, 3'd3, 12'h123, 3'd3);
        check("underrun_cnt", 32'(underrun_cnt), 32'(exp_und));

        // Abort after 7 rising edges: write of channel 1 must not land.
        sample_in    = 12'h777;
        sample_valid = 1'b1;
        exp_err_q.push_back(16'h0000);
`ifdef ADC_TEST_PATTERN_EN
        tb_ramp = tb_ramp + 12'd16;
`endif
        run_frame(16'h8400, 16, 7, rd);
        check("ctrl_word after abort", 32'(ctrl_word), 32'h0000);
        check("channel after abort", 32'(channel), 32'd3);

        full_frame(12'h2AB, 1'b1, 16'h0000, 16, 3'd3, 12'h2AB, 3'd3);
        // 20 SCLK cycles: edges 17-20 ignored and read as 0.
        full_frame(12'h0F0, 1'b1, 16'h8800, 20, 3'd3, 12'h0F0, 3'd2);

        // Reset in the middle of a frame.
        sample_in    = 12'h5A5;
        sample_valid = 1'b1;
        @(negedge CLK);
        ADC_CS_N = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            ADC_DIN = (i == 0);
            repeat (4) @(negedge CLK);
            ADC_SCLK = 1'b1;
            repeat (4) @(negedge CLK);
            ADC_SCLK = 1'b0;
        end
        RSTB = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_values("midreset");
        RSTB    = 1'b1;
        tb_ramp = 12'h000;
        for (int i = 0; i < 11; i++) begin
            ADC_DIN = 1'b1;
            repeat (4) @(negedge CLK);
            ADC_SCLK = 1'b1;
            repeat (4) @(negedge CLK);
            ADC_SCLK = 1'b0;
        end
        repeat (4) @(negedge CLK);
        ADC_CS_N = 1'b1;
        ADC_DIN  = 1'b0;
        repeat (8) @(negedge CLK);
        check("ctrl_word after lost frame", 32'(ctrl_word), 32'h0000);
        check("channel after lost frame", 32'(channel), 32'd0);

        full_frame(12'hABC, 1'b1, 16'h0000, 16, 3'd0, 12'hABC, 3'd0);

        repeat (10) @(negedge CLK);
        check("missing ctrl_valid", 32'(exp_ctrl_q.size()), 32'd0);
        check("missing frame_err", 32'(exp_err_q.size()), 32'd0);
        check("missing dout frame", 32'(exp_dout_q.size()), 32'd0);
        check("sample_ready pulses", 32'(ready_pulses), 32'(exp_ready));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
